ru_col_allocator: RTL

//  Converts the STW per-PE fault map into the redundant-unit (RU) allocation consumed by the BISR top,
//  the recompute_unit_controller and the recompute_module (ru_en, ru_col_mapping), plus the reverse column->RU table.

---
 rtl/ru_col_allocator_if.sv | 35 +++
 rtl/ru_col_allocator.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ru_col_allocator_if.sv
// Bundle between the STW fault-map source and the RU allocation consumers.
// The master drives the STW side; the slave, which is the allocator, returns the committed RU tables.
interface ru_col_allocator_if #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int NUM_RU = 4
);
    localparam int NUM_BITS_COLS = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int NUM_BITS_RU   = (NUM_RU > 1) ? $clog2(NUM_RU) : 1;
    localparam int CNT_W         = $clog2(COLS + 1);

    logic                            stw_complete;
    logic [ROWS*COLS-1:0]            fault_mat;
    logic                            clear_map;
    logic [NUM_RU-1:0]               ru_en;
    logic [NUM_BITS_COLS*NUM_RU-1:0] ru_col_mapping;
    logic [COLS-1:0]                 col_ru_valid;
    logic [NUM_BITS_RU*COLS-1:0]     col_ru_idx;
    logic [CNT_W-1:0]                faulty_col_count;
    logic                            alloc_overflow;
    logic                            alloc_busy;
    logic                            alloc_done;

    modport master (
        output stw_complete, fault_mat, clear_map,
        input  ru_en, ru_col_mapping, col_ru_valid, col_ru_idx,
               faulty_col_count, alloc_overflow, alloc_busy, alloc_done
    );

    modport slave (
        input  stw_complete, fault_mat, clear_map,
        output ru_en, ru_col_mapping, col_ru_valid, col_ru_idx,
               faulty_col_count, alloc_overflow, alloc_busy, alloc_done
    );
endinterface

// File: rtl/ru_col_allocator.sv
// Maps faulty systolic columns to redundant units, lowest column first, after each STW run.
// Latency: commit COLS+2 cycles after the stw_complete rising edge; no backpressure, edges during a scan are dropped.
module ru_col_allocator #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int NUM_RU = 4
) (
    input  logic             clk,
    input  logic             rst,
    ru_col_allocator_if.slave io
);
    localparam int NBC   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int NBR   = (NUM_RU > 1) ? $clog2(NUM_RU) : 1;
    localparam int CNT_W = $clog2(COLS + 1);
    localparam int RPW   = $clog2(NUM_RU + 1);

    localparam logic [RPW-1:0] RU_FULL  = RPW'(NUM_RU);
    localparam logic [NBC-1:0] COL_LAST = NBC'(COLS - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, SCAN, DONE} state_t;

    state_t                     state;
    logic                       stw_prev;
    logic [ROWS*COLS-1:0]       snap;
    logic [NBC-1:0]             col_ptr;
    logic [RPW-1:0]             ru_ptr;
    logic [CNT_W-1:0]           cnt;

    logic [NUM_RU-1:0]          wk_en;
    logic [NUM_RU-1:0][NBC-1:0] wk_map;
    logic [COLS-1:0]            wk_cv;
    logic [COLS-1:0][NBR-1:0]   wk_cidx;
    logic                       wk_ovf;

    logic [NUM_RU-1:0]          nxt_en;
    logic [NUM_RU-1:0][NBC-1:0] nxt_map;
    logic [COLS-1:0]            nxt_cv;
    logic [COLS-1:0][NBR-1:0]   nxt_cidx;
    logic                       nxt_ovf;
    logic [RPW-1:0]             nxt_ru_ptr;
    logic [CNT_W-1:0]           nxt_cnt;

    logic [NUM_RU-1:0]          ru_en_q;
    logic [NUM_RU-1:0][NBC-1:0] map_q;
    logic [COLS-1:0]            cv_q;
    logic [COLS-1:0][NBR-1:0]   cidx_q;
    logic [CNT_W-1:0]           cnt_q;
    logic                       ovf_q;
    logic                       busy_q;
    logic                       done_q;

    logic [COLS-1:0]            col_or;
    logic                       faulty;
    logic [NBR-1:0]             ru_idx;
    logic                       start;

    assign start  = (state == IDLE) && io.stw_complete && !stw_prev;
    assign ru_idx = ru_ptr[NBR-1:0];

    always_comb begin
        col_or = '0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                col_or[c] = col_or[c] | snap[r*COLS + c];
            end
        end
    end

    assign faulty = col_or[col_ptr];

    // Working tables as they will look once the current column is folded in;
    // the last column commits straight from here so DONE already shows the result.
    always_comb begin
        nxt_en     = wk_en;
        nxt_map    = wk_map;
        nxt_cv     = wk_cv;
        nxt_cidx   = wk_cidx;
        nxt_ovf    = wk_ovf;
        nxt_ru_ptr = ru_ptr;
        nxt_cnt    = cnt;
        if (faulty) begin
            nxt_cnt = cnt + CNT_W'(1);
            if (ru_ptr < RU_FULL) begin
                nxt_en[ru_idx]    = 1'b1;
                nxt_map[ru_idx]   = col_ptr;
                nxt_cv[col_ptr]   = 1'b1;
                nxt_cidx[col_ptr] = ru_idx;
                nxt_ru_ptr        = ru_ptr + RPW'(1);
            end else begin
                nxt_ovf = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            stw_prev <= 1'b1;
            snap     <= '0;
            col_ptr  <= '0;
            ru_ptr   <= '0;
            cnt      <= '0;
            wk_en    <= '0;
            wk_map   <= '0;
            wk_cv    <= '0;
            wk_cidx  <= '0;
            wk_ovf   <= 1'b0;
            ru_en_q  <= '0;
            map_q    <= '0;
            cv_q     <= '0;
            cidx_q   <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            stw_prev <= io.stw_complete;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= CAPTURE;
                        busy_q <= 1'b1;
                    end else if (io.clear_map) begin
                        ru_en_q <= '0;
                        map_q   <= '0;
                        cv_q    <= '0;
                        cidx_q  <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                CAPTURE: begin
                    snap    <= io.fault_mat;
                    col_ptr <= '0;
                    ru_ptr  <= '0;
                    cnt     <= '0;
                    wk_en   <= '0;
                    wk_map  <= '0;
                    wk_cv   <= '0;
                    wk_cidx <= '0;
                    wk_ovf  <= 1'b0;
                    state   <= SCAN;
                end
                SCAN: begin
                    wk_en   <= nxt_en;
                    wk_map  <= nxt_map;
                    wk_cv   <= nxt_cv;
                    wk_cidx <= nxt_cidx;
                    wk_ovf  <= nxt_ovf;
                    ru_ptr  <= nxt_ru_ptr;
                    cnt     <= nxt_cnt;
                    col_ptr <= col_ptr + NBC'(1);
                    if (col_ptr == COL_LAST) begin
                        ru_en_q <= nxt_en;
                        map_q   <= nxt_map;
                        cv_q    <= nxt_cv;
                        cidx_q  <= nxt_cidx;
                        cnt_q   <= nxt_cnt;
                        ovf_q   <= nxt_ovf;
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.ru_en            = ru_en_q;
    assign io.ru_col_mapping   = map_q;
    assign io.col_ru_valid     = cv_q;
    assign io.col_ru_idx       = cidx_q;
    assign io.faulty_col_count = cnt_q;
    assign io.alloc_overflow   = ovf_q;
    assign io.alloc_busy       = busy_q;
    assign io.alloc_done       = done_q;
endmodule
